// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous 64K x 8 RAM port between video
// scanout (read-only), the CPU and a DMA engine. One grant per cycle,
// fixed priority video > CPU > DMA, with a starvation counter that lifts a
// waiting DMA request to top priority after DMA_MAX_WAIT pass-overs.
// The RAM returns read data one cycle after the address, so the grantee of
// cycle N is remembered in owner_q and acknowledged in cycle N+1.
module mem_arbiter #(
  parameter int unsigned DMA_MAX_WAIT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data_o,
  output logic        mem_we,
  input  logic [7:0]  mem_data_i,
  input  logic        vid_req,
  input  logic [15:0] vid_address,
  output logic        vid_ack,
  output logic [7:0]  vid_data,
  input  logic        cpu_req,
  input  logic [15:0] cpu_address,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_data_o,
  output logic        cpu_ready,
  output logic [7:0]  cpu_data_i,
  input  logic        dma_req,
  input  logic [15:0] dma_address,
  input  logic        dma_we,
  input  logic [7:0]  dma_data_o,
  output logic        dma_ack,
  output logic [7:0]  dma_data
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

  localparam logic [7:0] WAIT_MAX = 8'(DMA_MAX_WAIT);

  // Owner of the access whose completion is due this cycle
  owner_e      owner_q, owner_d;
  logic        owner_we_q, owner_we_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic [7:0]  cpu_data_q, cpu_data_d;
  logic [7:0]  dma_data_q, dma_data_d;

  logic        vid_elig_s;
  logic        cpu_elig_s;
  logic        dma_elig_s;
  logic        dma_force_s;
  logic [15:0] grant_addr_s;
  logic [7:0]  grant_wdata_s;
  logic        grant_we_s;

  // A requester whose ack is due this cycle is still holding the request
  // that was just served, so it must sit out one cycle.
  always_comb begin
    vid_elig_s  = vid_req && (owner_q != OWN_VID);
    cpu_elig_s  = cpu_req && (owner_q != OWN_CPU);
    dma_elig_s  = dma_req && (owner_q != OWN_DMA);
    dma_force_s = dma_elig_s && (wait_cnt_q == WAIT_MAX);
  end

  // Grant decision: starved DMA first, then video > CPU > DMA
  always_comb begin
    owner_d = OWN_NONE;
    if (dma_force_s) begin
      owner_d = OWN_DMA;
    end else if (vid_elig_s) begin
      owner_d = OWN_VID;
    end else if (cpu_elig_s) begin
      owner_d = OWN_CPU;
    end else if (dma_elig_s) begin
      owner_d = OWN_DMA;
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // Steer the granted requester's address/data/we onto the RAM port
  always_comb begin
    grant_addr_s  = 16'h0000;
    grant_wdata_s = 8'h00;
    grant_we_s    = 1'b0;
    case (owner_d)
      OWN_VID: begin
        grant_addr_s  = vid_address;
        grant_wdata_s = 8'h00;
        grant_we_s    = 1'b0;
      end
      OWN_CPU: begin
        grant_addr_s  = cpu_address;
        grant_wdata_s = cpu_data_o;
        grant_we_s    = cpu_we;
      end
      OWN_DMA: begin
        grant_addr_s  = dma_address;
        grant_wdata_s = dma_data_o;
        grant_we_s    = dma_we;
      end
      default: begin
        grant_addr_s  = 16'h0000;
        grant_wdata_s = 8'h00;
        grant_we_s    = 1'b0;
      end
    endcase
    owner_we_d = grant_we_s;
  end

  // RAM port is parked (no write, address 0) whenever reset is asserted,
  // independent of the clock.
  always_comb begin
    if (reset_n) begin
      mem_address = grant_addr_s;
      mem_data_o  = grant_wdata_s;
      mem_we      = grant_we_s;
    end else begin
      mem_address = 16'h0000;
      mem_data_o  = 8'h00;
      mem_we      = 1'b0;
    end
  end

  // DMA starvation counter: counts pass-overs, clears on grant or idle
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dma_req) begin
      wait_cnt_d = 8'd0;
    end else if (owner_d == OWN_DMA) begin
      wait_cnt_d = 8'd0;
    end else if (dma_elig_s && (wait_cnt_q < WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Completion: ack follows owner_q; read data passes straight through in
  // the ack cycle and is held afterwards. Writes leave held data untouched.
  always_comb begin
    vid_ack    = (owner_q == OWN_VID);
    cpu_ready  = (owner_q == OWN_CPU);
    dma_ack    = (owner_q == OWN_DMA);
    vid_data_d = vid_data_q;
    cpu_data_d = cpu_data_q;
    dma_data_d = dma_data_q;
    if (vid_ack && !owner_we_q) begin
      vid_data_d = mem_data_i;
    end else begin
      vid_data_d = vid_data_q;
    end
    if (cpu_ready && !owner_we_q) begin
      cpu_data_d = mem_data_i;
    end else begin
      cpu_data_d = cpu_data_q;
    end
    if (dma_ack && !owner_we_q) begin
      dma_data_d = mem_data_i;
    end else begin
      dma_data_d = dma_data_q;
    end
    vid_data   = vid_data_d;
    cpu_data_i = cpu_data_d;
    dma_data   = dma_data_d;
  end

  // Owner/starvation state; reset discards any in-flight access
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q    <= OWN_NONE;
      owner_we_q <= 1'b0;
      wait_cnt_q <= 8'd0;
    end else begin
      owner_q    <= owner_d;
      owner_we_q <= owner_we_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Held read-data registers for each requester
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vid_data_q <= 8'h00;
      cpu_data_q <= 8'h00;
      dma_data_q <= 8'h00;
    end else begin
      vid_data_q <= vid_data_d;
      cpu_data_q <= cpu_data_d;
      dma_data_q <= dma_data_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Each requester agent
// loads transactions from its stimulus queue, pushes the expected result
// (computed from a bench-side shadow memory) to a scoreboard queue, and the
// matching ack pops and checks it together with the RAM port drive seen in
// the grant cycle.
module tb_mem_arbiter;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } rec_t;

  logic        clock;
  logic        reset_n;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_o;
  logic        mem_we;
  logic [7:0]  mem_data_i;
  logic        vid_ack, cpu_ready, dma_ack;
  logic [7:0]  vid_data, cpu_data_i, dma_data;

  logic        req_a  [3];
  logic [15:0] addr_a [3];
  logic        we_a   [3];
  logic [7:0]  wd_a   [3];
  logic [2:0]  ack_v;
  logic [7:0]  dout_a [3];

  rec_t        tx_q [3][$];
  rec_t        sb_q [3][$];
  logic [7:0]  held [3];
  int          ack_log [$];
  string       nm [3] = '{"vid", "cpu", "dma"};

  logic [7:0]  ram    [0:65535];
  logic [7:0]  shadow [0:65535];
  logic [15:0] port_addr;
  logic        port_we;
  logic [7:0]  port_wd;
  logic        agent_en;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.DMA_MAX_WAIT(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mem_address (mem_address),
    .mem_data_o  (mem_data_o),
    .mem_we      (mem_we),
    .mem_data_i  (mem_data_i),
    .vid_req     (req_a[0]),
    .vid_address (addr_a[0]),
    .vid_ack     (vid_ack),
    .vid_data    (vid_data),
    .cpu_req     (req_a[1]),
    .cpu_address (addr_a[1]),
    .cpu_we      (we_a[1]),
    .cpu_data_o  (wd_a[1]),
    .cpu_ready   (cpu_ready),
    .cpu_data_i  (cpu_data_i),
    .dma_req     (req_a[2]),
    .dma_address (addr_a[2]),
    .dma_we      (we_a[2]),
    .dma_data_o  (wd_a[2]),
    .dma_ack     (dma_ack),
    .dma_data    (dma_data)
  );

  assign ack_v     = {dma_ack, cpu_ready, vid_ack};
  assign dout_a[0] = vid_data;
  assign dout_a[1] = cpu_data_i;
  assign dout_a[2] = dma_data;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM model: registered read, write at the clock edge
  always @(posedge clock) begin
    if (mem_we) ram[mem_address] <= mem_data_o;
    mem_data_i <= ram[mem_address];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [15:0] a, input logic w, input logic [7:0] d);
    rec_t r;
    r.addr = a; r.we = w; r.wdata = d; r.rdata = 8'h00;
    return r;
  endfunction

  // Requester agents and scoreboard checker, active on the falling edge
  initial begin : agent
    rec_t r;
    int   nack;
    int   code;
    forever begin
      @(negedge clock);
      if (agent_en) begin
        nack = 0;
        code = 0;
        for (int i = 0; i < 3; i++) if (ack_v[i]) begin nack++; code = i + 1; end
        ack_log.push_back(code);
        check_eq("ack_onehot", 32'(nack <= 1), 32'd1);
        if (nack == 0) begin
          check_eq("idle_we", 32'(port_we), 32'd0);
          check_eq("idle_addr", 32'(port_addr), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
          if (ack_v[i]) begin
            if (sb_q[i].size() == 0) begin
              check_eq({nm[i], "_spurious_ack"}, 32'd1, 32'd0);
            end else begin
              r = sb_q[i].pop_front();
              check_eq({nm[i], "_addr"}, 32'(port_addr), 32'(r.addr));
              check_eq({nm[i], "_we"}, 32'(port_we), 32'(r.we));
              if (r.we) begin
                check_eq({nm[i], "_wdata"}, 32'(port_wd), 32'(r.wdata));
                check_eq({nm[i], "_hold_on_write"}, 32'(dout_a[i]), 32'(held[i]));
              end else begin
                check_eq({nm[i], "_rdata"}, 32'(dout_a[i]), 32'(r.rdata));
                held[i] = r.rdata;
              end
            end
            req_a[i] = 1'b0;
          end else begin
            check_eq({nm[i], "_hold"}, 32'(dout_a[i]), 32'(held[i]));
          end
        end
        for (int i = 0; i < 3; i++) begin
          if (!req_a[i] && tx_q[i].size() > 0) begin
            r = tx_q[i].pop_front();
            r.rdata = shadow[r.addr];
            if (r.we) shadow[r.addr] = r.wdata;
            addr_a[i] = r.addr;
            we_a[i]   = r.we;
            wd_a[i]   = r.wdata;
            req_a[i]  = 1'b1;
            sb_q[i].push_back(r);
          end
        end
      end
      #4;
      port_addr = mem_address;
      port_we   = mem_we;
      port_wd   = mem_data_o;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((tx_q[0].size() + tx_q[1].size() + tx_q[2].size() +
            sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 ||
           req_a[0] || req_a[1] || req_a[2]) begin
      @(posedge clock);
      n++;
      if (n > 500) begin
        check_eq("idle_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_seq(input string tag, input string exp);
    int c;
    check_eq({tag, "_len"}, 32'(ack_log.size() > exp.len()), 32'd1);
    for (int i = 0; i < exp.len(); i++) begin
      c = (exp.getc(i) == "V") ? 1 : (exp.getc(i) == "C") ? 2 : 3;
      check_eq(tag, (i + 1 < ack_log.size()) ? 32'(ack_log[i + 1]) : 32'hFF, 32'(c));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    end
    ram[16'h1234] = 8'hA5;
    shadow[16'h1234] = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      req_a[i] = 1'b0; addr_a[i] = 16'h0000; we_a[i] = 1'b0; wd_a[i] = 8'h00; held[i] = 8'h00;
    end
    agent_en = 1'b0;
    reset_n  = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_vid_ack", 32'(vid_ack), 32'd0);
    check_eq("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check_eq("rst_dma_ack", 32'(dma_ack), 32'd0);
    check_eq("rst_vid_data", 32'(vid_data), 32'd0);
    check_eq("rst_cpu_data", 32'(cpu_data_i), 32'd0);
    check_eq("rst_dma_data", 32'(dma_data), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_address), 32'd0);
    reset_n  = 1'b1;
    agent_en = 1'b1;
    @(posedge clock);
    #1;

    // CPU read of preloaded location
    tx_q[1].push_back(mk(16'h1234, 1'b0, 8'h00));
    wait_idle();
    check_eq("t1_cpu_data_held", 32'(cpu_data_i), 32'hA5);

    // CPU write/read-back, including the top address
    tx_q[1].push_back(mk(16'h8000, 1'b1, 8'h42));
    tx_q[1].push_back(mk(16'h8000, 1'b0, 8'h00));
    tx_q[1].push_back(mk(16'hFFFF, 1'b1, 8'hC3));
    tx_q[1].push_back(mk(16'hFFFF, 1'b0, 8'h00));
    wait_idle();
    check_eq("t2_cpu_data_held", 32'(cpu_data_i), 32'hC3);

    // Video and CPU streaming interleave
    ack_log.delete();
    for (int k = 0; k < 6; k++) begin
      tx_q[0].push_back(mk(16'h0100 + 16'(k), 1'b0, 8'h00));
      tx_q[1].push_back(mk(16'h0200 + 16'(k), 1'b0, 8'h00));
    end
    wait_idle();
    check_seq("t3_interleave", "VCVCVCVCVCVC");

    // DMA starvation relief with video and CPU saturating
    ack_log.delete();
    for (int k = 0; k < 20; k++) begin
      tx_q[0].push_back(mk(16'h1000 + 16'(k), 1'b0, 8'h00));
      tx_q[1].push_back(mk(16'h2000 + 16'(k), 1'b0, 8'h00));
    end
    for (int k = 0; k < 3; k++) tx_q[2].push_back(mk(16'h3000 + 16'(k), 1'b0, 8'h00));
    wait_idle();
    check_seq("t4_starve", "VCVCVCVCDVCVCVCVCVDVCVCVCVCVD");

    // All three at once with counter at zero
    ack_log.delete();
    tx_q[0].push_back(mk(16'h0500, 1'b0, 8'h00));
    tx_q[1].push_back(mk(16'h0600, 1'b0, 8'h00));
    tx_q[2].push_back(mk(16'h4000, 1'b1, 8'h77));
    wait_idle();
    check_seq("t5_all_three", "VCD");

    // CPU reads back the DMA write
    tx_q[1].push_back(mk(16'h4000, 1'b0, 8'h00));
    wait_idle();
    check_eq("t6_cpu_sees_dma_write", 32'(cpu_data_i), 32'h77);

    // Reset asserted in the ack cycle of a CPU read
    agent_en = 1'b0;
    @(negedge clock);
    addr_a[1] = 16'h1234; we_a[1] = 1'b0; wd_a[1] = 8'h00; req_a[1] = 1'b1;
    #1;
    check_eq("t7_grant_addr", 32'(mem_address), 32'h1234);
    check_eq("t7_grant_we", 32'(mem_we), 32'd0);
    @(posedge clock);
    #1;
    we_a[1] = 1'b1; wd_a[1] = 8'h99;
    reset_n = 1'b0;
    #1;
    check_eq("t7_rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check_eq("t7_rst_cpu_data", 32'(cpu_data_i), 32'd0);
    check_eq("t7_rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("t7_rst_mem_addr", 32'(mem_address), 32'd0);
    @(negedge clock);
    req_a[1] = 1'b0; we_a[1] = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_eq("t7_no_spurious_ack", 32'(ack_v), 32'd0);
      check_eq("t7_cpu_data_cleared", 32'(cpu_data_i), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one 64K x 8 synchronous RAM port between three requesters: video scanout (read-only), the z80 CPU, and a DMA engine.
- The RAM registers its read data: an address presented in cycle N returns data in cycle N+1. A write is committed at the edge ending cycle N.
- Grants at most one access per cycle, returns read data to its owner, and guarantees DMA forward progress through a starvation counter.

Parameters:
- DMA_MAX_WAIT, 8, cycles an eligible pending DMA request may be passed over before it is forced to top priority (1..255).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mem_address  out  16  RAM address
- mem_data_o  out  8  RAM write data
- mem_we  out  1  RAM write enable
- mem_data_i  in  8  RAM read data, valid one cycle after its address
- vid_req  in  1  video read request
- vid_address  in  16  video address
- vid_ack  out  1  video data valid pulse
- vid_data  out  8  video read data
- cpu_req  in  1  CPU request
- cpu_address  in  16  CPU address
- cpu_we  in  1  CPU write, 0 = read
- cpu_data_o  in  8  CPU write data
- cpu_ready  out  1  CPU access complete pulse
- cpu_data_i  out  8  CPU read data
- dma_req  in  1  DMA request
- dma_address  in  16  DMA address
- dma_we  in  1  DMA write
- dma_data_o  in  8  DMA write data
- dma_ack  out  1  DMA access complete pulse
- dma_data  out  8  DMA read data

Behaviour:
- Clock and reset: one clock domain (clock). reset_n is asynchronous and active-low.
- Reset state: vid_ack, cpu_ready and dma_ack are 0. The held data outputs are 0x00. The owner register is NONE and wait_cnt is 0. While reset_n is low, mem_we is forced to 0 and mem_address to 0x0000.
- Handshake:
  - A requester raises req with address/we/data and holds them stable until its ack/ready pulse.
  - The ack pulse lasts one cycle.
  - In the ack cycle the requester may drop req or present a new request.
- Lockout: a requester whose ack is due in the current cycle (owner_q == that requester) is ineligible for grant this cycle. This prevents a duplicate grant of the held request.
- Grant decision (combinational, each cycle, among eligible requesters with req=1):
  - If DMA is eligible and pending and wait_cnt == DMA_MAX_WAIT, grant DMA.
  - Otherwise priority is video > CPU > DMA.
  - If nobody is eligible and pending, there is no grant.
- Memory port drive:
  - On a grant, mem_address, mem_data_o and mem_we come from the granted requester.
  - mem_we is asserted only when the granted access is a write.
  - With no grant: mem_we=0, mem_address=0x0000, mem_data_o=0x00.
- Completion:
  - owner_q registers the grantee (or NONE) at the end of each cycle.
  - In cycle N+1 the ack matching owner_q is 1; for writes the ack is also given.
  - For a read, the matching data output equals mem_data_i in the ack cycle, is captured at the end of that cycle, and is held until the next read completion for that requester. Writes do not change the held data.
- Starvation counter wait_cnt, 8-bit:
  - Increments each cycle DMA is eligible and pending but not granted.
  - Clears to 0 on a DMA grant or when dma_req=0.
  - Saturates at DMA_MAX_WAIT.
- Throughput:
  - Up to one access per cycle in aggregate.
  - A single requester gets at most one access per 2 cycles.
  - Video and CPU both streaming interleave V,C,V,C.
- Boundary cases:
  - Address 0xFFFF is passed unchanged; no wrap logic.
  - Simultaneous all-request with wait_cnt at max grants DMA.
  - Requests arriving in the same cycle as an unrelated ack are eligible.
- Reset mid-operation: any in-flight access is discarded and no ack is issued after reset_n rises. A write granted in the cycle reset asserts is not guaranteed committed.

Test Plan:
- Reset, then CPU read 0x1234 (RAM holds 0xA5): grant in cycle N → mem_address=0x1234, mem_we=0 in N; cpu_ready=1 and cpu_data_i=0xA5 in N+1; cpu_data_i holds 0xA5 afterwards.
- CPU write 0x42 to 0x8000, then CPU read 0x8000 → mem_we=1 only in the grant cycle; the following read returns 0x42.
- vid_req and cpu_req held continuously from cycle 0 → grants V,C,V,C…; vid_ack and cpu_ready alternate every cycle after the first.
- Video and CPU saturating, dma_req held with DMA_MAX_WAIT=8 → DMA is never granted until wait_cnt reaches 8; then DMA is granted once, wait_cnt clears, and the pattern repeats.
- All three requests in the same cycle with wait_cnt=0 → video granted first; CPU granted next cycle; DMA granted in the first cycle where video and CPU are both ineligible or idle.
- Pull reset_n low in the cycle after a CPU read grant → cpu_ready stays 0, cpu_data_i=0x00, mem_we=0 immediately (asynchronously); after release there is no spurious ack.
